// File: rtl/crc_lut_pkg.sv
// Shared types and constants for the runtime-generated CRC lookup table bank.
// Holds the FSM state encoding and the slice-index width helper.
package crc_lut_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_GEN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_READY = 2'd3
   } state_t;

   localparam int TABLE_DEPTH = 256;
   localparam int BYTE_W      = 8;

   // Width of the slice index; at least one bit even for a single table.
   function automatic int slice_idx_w(input int n);
      int w;
      w = 1;
      for (int b = 1; b < 31; b++) begin
         if ((1 << b) < n) w = b + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Advances a CRC register by one byte of zero input (eight bit-steps).
// REFIN selects right-shifting reflected or left-shifting normal bit order.
module crc_byte_step
   import crc_lut_pkg::*;
#(
   parameter int CRC_W = 32,
   parameter bit REFIN = 1'b1
) (
   input  logic [CRC_W-1:0] crc,
   input  logic [CRC_W-1:0] poly,
   output logic [CRC_W-1:0] crc_next
);

   logic [CRC_W-1:0] w_c;

   always_comb begin
      w_c = crc;
      for (int b = 0; b < BYTE_W; b++) begin
         if (REFIN) w_c = w_c[0] ? ((w_c >> 1) ^ poly) : (w_c >> 1);
         else       w_c = w_c[CRC_W-1] ? ((w_c << 1) ^ poly) : (w_c << 1);
      end
      crc_next = w_c;
   end

endmodule

// File: rtl/crc_lut_bank.sv
// Bank of NUM_SLICES 256-entry CRC lookup tables filled in hardware from a runtime
// polynomial, serving one registered lookup per slice per cycle once ready.
module crc_lut_bank
   import crc_lut_pkg::*;
#(
   parameter int NUM_SLICES = 8,
   parameter int CRC_W      = 32,
   parameter bit REFIN      = 1'b1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [CRC_W-1:0]             poly,
   input  logic                         init_req,
   output logic                         init_busy,
   output logic                         init_done,
   output logic                         lk_ready,
   input  logic                         lk_valid,
   input  logic [NUM_SLICES*BYTE_W-1:0] lk_addr,
   output logic [NUM_SLICES*CRC_W-1:0]  lk_data,
   output logic                         lk_data_valid,
   output state_t                       dbg_state
);

   localparam int K_W = slice_idx_w(NUM_SLICES);

   if (CRC_W < 8 || CRC_W > 64) begin : g_bad_crc_w
      $error("crc_lut_bank: CRC_W must be within 8..64");
   end
   if (NUM_SLICES < 1) begin : g_bad_slices
      $error("crc_lut_bank: NUM_SLICES must be at least 1");
   end

   state_t           r_state;
   logic [CRC_W-1:0] r_poly;
   logic [CRC_W-1:0] r_crc;
   logic [7:0]       r_i;
   logic [K_W-1:0]   r_k;
   logic             r_busy;
   logic             r_done;
   logic             r_ready;
   logic             r_dv;

   logic [CRC_W-1:0] w_seed;
   logic [CRC_W-1:0] w_step_in;
   logic [CRC_W-1:0] w_step;
   logic             w_we;
   logic             w_last_k;
   logic             w_accept;

   // Slice 0 restarts from the byte seed; later slices keep stepping the previous entry.
   always_comb begin
      if (REFIN) w_seed = CRC_W'(r_i);
      else       w_seed = CRC_W'(r_i) << (CRC_W - BYTE_W);
      w_step_in = (r_k == '0) ? w_seed : r_crc;
   end

   assign w_we     = (r_state == ST_GEN);
   assign w_last_k = (r_k == K_W'(NUM_SLICES - 1));
   assign w_accept = lk_valid && r_ready;

   crc_byte_step #(
      .CRC_W (CRC_W),
      .REFIN (REFIN)
   ) u_step (
      .crc      (w_step_in),
      .poly     (r_poly),
      .crc_next (w_step)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_START;
         r_poly  <= '0;
         r_crc   <= '0;
         r_i     <= '0;
         r_k     <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_START: begin
               r_poly  <= poly;
               r_i     <= '0;
               r_k     <= '0;
               r_busy  <= 1'b1;
               r_state <= ST_GEN;
            end
            ST_GEN: begin
               r_crc <= w_step;
               if (w_last_k) begin
                  r_k <= '0;
                  if (r_i == 8'hFF) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_i <= r_i + 8'd1;
                  end
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            ST_DONE: begin
               r_ready <= 1'b1;
               r_state <= ST_READY;
            end
            ST_READY: begin
               // A lookup accepted this same cycle still reads the old tables.
               if (init_req) begin
                  r_state <= ST_START;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            default: r_state <= ST_START;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_dv <= 1'b0;
      else       r_dv <= w_accept;
   end

   for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
      logic [CRC_W-1:0] r_mem [TABLE_DEPTH];
      logic [CRC_W-1:0] r_rd;

      always_ff @(posedge clk) begin
         if (w_we && (r_k == K_W'(s))) r_mem[r_i] <= w_step;
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)         r_rd <= '0;
         else if (w_accept) r_rd <= r_mem[lk_addr[s*BYTE_W +: BYTE_W]];
      end

      assign lk_data[s*CRC_W +: CRC_W] = r_rd;
   end

   assign init_busy     = r_busy;
   assign init_done     = r_done;
   assign lk_ready      = r_ready;
   assign lk_data_valid = r_dv;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_crc_lut_bank.sv
// Bench for crc_lut_bank: reflected CRC-32 bank plus two normal-order instances,
// checked against a bit-serial CRC model through a lookup scoreboard.
module tb_crc_lut_bank;
   import crc_lut_pkg::*;

   localparam logic [31:0] POLY_A = 32'hEDB88320;
   localparam logic [31:0] POLY_B = 32'h82F63B78;

   // clock / reset
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // main reflected instance
   logic [31:0]  poly;
   logic         init_req;
   logic         init_busy, init_done, lk_ready, lk_valid, lk_data_valid;
   logic [63:0]  lk_addr;
   logic [255:0] lk_data;
   state_t       dbg_state;

   // normal-order instances
   logic         req_off = 1'b0;
   logic         lk_valid_n;
   logic [31:0]  poly_n32 = 32'h04C11DB7;
   logic [15:0]  poly_n16 = 16'h1021;
   logic [15:0]  addr_n32;
   logic [7:0]   addr_n16;
   logic [63:0]  data_n32;
   logic [15:0]  data_n16;
   logic         busy_n32, done_n32, ready_n32, dv_n32;
   logic         busy_n16, done_n16, ready_n16, dv_n16;
   state_t       st_n32, st_n16;

   crc_lut_bank #(.NUM_SLICES(8), .CRC_W(32), .REFIN(1'b1)) dut (
      .clk(clk), .rstn(rstn), .poly(poly), .init_req(init_req),
      .init_busy(init_busy), .init_done(init_done), .lk_ready(lk_ready),
      .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_data(lk_data),
      .lk_data_valid(lk_data_valid), .dbg_state(dbg_state)
   );

   crc_lut_bank #(.NUM_SLICES(2), .CRC_W(32), .REFIN(1'b0)) dut_n32 (
      .clk(clk), .rstn(rstn), .poly(poly_n32), .init_req(req_off),
      .init_busy(busy_n32), .init_done(done_n32), .lk_ready(ready_n32),
      .lk_valid(lk_valid_n), .lk_addr(addr_n32), .lk_data(data_n32),
      .lk_data_valid(dv_n32), .dbg_state(st_n32)
   );

   crc_lut_bank #(.NUM_SLICES(1), .CRC_W(16), .REFIN(1'b0)) dut_n16 (
      .clk(clk), .rstn(rstn), .poly(poly_n16), .init_req(req_off),
      .init_busy(busy_n16), .init_done(done_n16), .lk_ready(ready_n16),
      .lk_valid(lk_valid_n), .lk_addr(addr_n16), .lk_data(data_n16),
      .lk_data_valid(dv_n16), .dbg_state(st_n16)
   );

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [255:0] exp_q[$];
   logic [255:0] last_exp = '0;
   logic [31:0]  m_tab [8][256];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // bit-serial CRC of one data byte followed by 'zeros' zero bytes, zero initial value
   function automatic logic [63:0] crc_ser(input logic [63:0] p, input int w, input bit refl,
                                           input logic [7:0] b, input int zeros);
      logic [63:0] c, mask;
      logic fb, bit_v;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      c = '0;
      for (int n = 0; n <= zeros; n++) begin
         for (int j = 0; j < 8; j++) begin
            bit_v = (n == 0) ? (refl ? b[j] : b[7-j]) : 1'b0;
            if (refl) begin
               fb = c[0] ^ bit_v;
               c  = c >> 1;
            end else begin
               fb = c[w-1] ^ bit_v;
               c  = (c << 1) & mask;
            end
            if (fb) c = c ^ p;
         end
      end
      return c;
   endfunction

   // slice 0 from the bit-serial model, later slices from the table recurrence
   task automatic build_model(input logic [31:0] p);
      logic [31:0] t;
      for (int i = 0; i < 256; i++) m_tab[0][i] = 32'(crc_ser(64'(p), 32, 1'b1, 8'(i), 0));
      for (int k = 1; k < 8; k++) begin
         for (int i = 0; i < 256; i++) begin
            t = m_tab[k-1][i];
            m_tab[k][i] = (t >> 8) ^ m_tab[0][t[7:0]];
         end
      end
   endtask

   function automatic logic [255:0] exp_bus(input logic [63:0] a);
      logic [255:0] r;
      for (int s = 0; s < 8; s++) r[s*32 +: 32] = m_tab[s][a[s*8 +: 8]];
      return r;
   endfunction

   // scoreboard: pop on every response, otherwise lk_data must hold
   always @(negedge clk) begin
      if (!rstn) begin
         last_exp = '0;
      end else begin
         if (init_done) done_cnt++;
         if (lk_data_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL unexpected_rsp observed=%0h expected=no_response", lk_data);
            end
            if (exp_q.size() != 0) begin
               last_exp = exp_q.pop_front();
               chk("lookup_data", lk_data, last_exp);
            end
         end else begin
            chk("lk_data_hold", lk_data, last_exp);
         end
      end
   end

   // drive one lookup at the current negedge, return at the next negedge
   task automatic do_lookup(input logic [63:0] a, input bit expect_rsp);
      lk_valid = 1'b1;
      lk_addr  = a;
      if (expect_rsp) exp_q.push_back(exp_bus(a));
      @(negedge clk);
      lk_valid = 1'b0;
   endtask

   task automatic sweep_all();
      logic [63:0] a;
      for (int i = 0; i < 256; i++) begin
         for (int s = 0; s < 8; s++) a[s*8 +: 8] = 8'(i + 31 * s);
         lk_valid = 1'b1;
         lk_addr  = a;
         exp_q.push_back(exp_bus(a));
         @(negedge clk);
      end
      lk_valid = 1'b0;
      @(negedge clk);
   endtask

   // called at the negedge where the FSM sits in START
   task automatic wait_gen(input string tag, input logic [31:0] p, input int pulse_at);
      int cnt;
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 5000) begin
         cnt++;
         @(negedge clk);
         if (cnt == 1) poly = ~p;
         init_req = (cnt == pulse_at);
         lk_valid = 1'($urandom_range(0, 1));
         lk_addr  = {$urandom, $urandom};
      end
      init_req = 1'b0;
      lk_valid = 1'b0;
      chk({tag, "_busy_cycles"}, 256'(cnt), 256'(2049));
      chk({tag, "_done_pulse"}, 256'(init_done), 256'(1));
      chk({tag, "_ready_in_done"}, 256'(lk_ready), 256'(0));
      @(negedge clk);
      chk({tag, "_ready"}, 256'(lk_ready), 256'(1));
      chk({tag, "_done_low"}, 256'(init_done), 256'(0));
      chk({tag, "_state"}, 256'(dbg_state), 256'(ST_READY));
      poly = p;
   endtask

   initial begin
      int dc;
      logic v;
      poly = POLY_A;
      init_req = 1'b0;
      lk_valid = 1'b0;
      lk_addr = '0;
      lk_valid_n = 1'b0;
      addr_n32 = '0;
      addr_n16 = '0;
      build_model(POLY_A);

      repeat (3) @(negedge clk);
      chk("rst_busy", 256'(init_busy), 256'(1));
      chk("rst_done", 256'(init_done), 256'(0));
      chk("rst_ready", 256'(lk_ready), 256'(0));
      chk("rst_data", lk_data, 256'(0));
      chk("rst_dv", 256'(lk_data_valid), 256'(0));
      chk("rst_state", 256'(dbg_state), 256'(ST_START));

      rstn = 1'b1;
      dc = done_cnt;
      wait_gen("boot", POLY_A, -1);
      chk("boot_done_count", 256'(done_cnt), 256'(dc + 1));

      do_lookup({8{8'h01}}, 1'b1);
      chk("crc32_a01", 256'(lk_data[31:0]), 256'(32'h77073096));
      do_lookup({8{8'h80}}, 1'b1);
      chk("crc32_a80", 256'(lk_data[31:0]), 256'(32'hEDB88320));
      do_lookup({8{8'hFF}}, 1'b1);
      chk("crc32_aff", 256'(lk_data[31:0]), 256'(32'h2D02EF8D));
      @(negedge clk);
      chk("idle_dv", 256'(lk_data_valid), 256'(0));

      // normal-order instances
      chk("n32_ready", 256'(ready_n32), 256'(1));
      chk("n16_ready", 256'(ready_n16), 256'(1));
      lk_valid_n = 1'b1;
      addr_n32 = {8'h5A, 8'h01};
      addr_n16 = 8'h01;
      @(negedge clk);
      addr_n32 = {8'h01, 8'hFF};
      addr_n16 = 8'hC3;
      chk("n32_dv", 256'(dv_n32), 256'(1));
      chk("n32_s0_a01", 256'(data_n32[31:0]), 256'(32'h04C11DB7));
      chk("n32_s1_a5a", 256'(data_n32[63:32]), 256'(crc_ser(64'(poly_n32), 32, 1'b0, 8'h5A, 1)));
      chk("n16_a01", 256'(data_n16), 256'(16'h1021));
      @(negedge clk);
      lk_valid_n = 1'b0;
      chk("n16_dv", 256'(dv_n16), 256'(1));
      chk("n16_ac3", 256'(data_n16), 256'(crc_ser(64'(poly_n16), 16, 1'b0, 8'hC3, 0)));
      chk("n32_s0_aff", 256'(data_n32[31:0]), 256'(crc_ser(64'(poly_n32), 32, 1'b0, 8'hFF, 0)));
      chk("n32_s1_a01", 256'(data_n32[63:32]), 256'(crc_ser(64'(poly_n32), 32, 1'b0, 8'h01, 1)));
      @(negedge clk);
      chk("n32_idle_dv", 256'(dv_n32), 256'(0));
      chk("n16_hold", 256'(data_n16), 256'(crc_ser(64'(poly_n16), 16, 1'b0, 8'hC3, 0)));

      sweep_all();

      for (int n = 0; n < 80; n++) begin
         v = ($urandom_range(0, 3) != 0);
         lk_valid = v;
         lk_addr  = {$urandom, $urandom};
         if (v) exp_q.push_back(exp_bus(lk_addr));
         @(negedge clk);
      end
      lk_valid = 1'b0;
      @(negedge clk);

      // re-init with a lookup in the same cycle, plus an ignored request mid-GEN
      poly = POLY_B;
      init_req = 1'b1;
      lk_valid = 1'b1;
      lk_addr = {8{8'h80}};
      exp_q.push_back(exp_bus(lk_addr));
      @(negedge clk);
      init_req = 1'b0;
      lk_valid = 1'b0;
      chk("reinit_old_dv", 256'(lk_data_valid), 256'(1));
      chk("reinit_old_data", 256'(lk_data[31:0]), 256'(POLY_A));
      chk("reinit_ready_low", 256'(lk_ready), 256'(0));
      chk("reinit_busy", 256'(init_busy), 256'(1));
      build_model(POLY_B);
      dc = done_cnt;
      wait_gen("reinit", POLY_B, 300);
      repeat (20) @(negedge clk);
      chk("ignored_req_state", 256'(dbg_state), 256'(ST_READY));
      chk("ignored_req_busy", 256'(init_busy), 256'(0));
      chk("ignored_req_done_count", 256'(done_cnt), 256'(dc + 1));
      do_lookup({8{8'h80}}, 1'b1);
      chk("new_poly_a80", 256'(lk_data[31:0]), 256'(POLY_B));

      // reset in the middle of generation
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      repeat (700) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 256'(lk_ready), 256'(0));
      chk("midrst_state", 256'(dbg_state), 256'(ST_START));
      @(negedge clk);
      poly = POLY_B;
      rstn = 1'b1;
      dc = done_cnt;
      wait_gen("midrst", POLY_B, -1);
      chk("midrst_done_count", 256'(done_cnt), 256'(dc + 1));
      sweep_all();

      repeat (3) @(negedge clk);
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
